// File: rtl/vconv_pkg.sv
// Shared types and the [1 2 1] kernel for the vertical Gaussian stage.
// Optional macro VCONV_ROUND_EN: round half up instead of truncating.
package vconv_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 10;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } vstate_e;

  // Returns a + 2b + c; the caller keeps bits [9:2] as the output pixel.
  function automatic logic [SUM_W-1:0] g121(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    logic [SUM_W-1:0] s;
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
`ifdef VCONV_ROUND_EN
    s = s + SUM_W'(2);
`endif
    return s;
  endfunction

endpackage

// File: rtl/vlinebuf.sv
// One image row of storage: synchronous write, asynchronous read, shared address.
module vlinebuf #(
  parameter int DEPTH = 520,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/vconvg8_stream.sv
// Vertical [1 2 1]/4 Gaussian over a raster stream with top/bottom row replication.
// Optional macro VCONV_ROUND_EN selects round-half-up; default build truncates.
module vconvg8_stream
  import vconv_pkg::*;
#(
  parameter int IM_LEN  = 520,
  parameter int IM_ROWS = 520
) (
  input  logic             clk,
  input  logic             vres_n,
  input  logic             vclrbuffer,
  input  logic [PIX_W-1:0] vin,
  input  logic             vin_valid,
  output logic             vin_ready,
  output logic [PIX_W-1:0] vout,
  output logic             vout_valid,
  input  logic             vout_ready,
  output logic             frame_done
);

  localparam int CW = $clog2(IM_LEN);
  localparam int RW = $clog2(IM_ROWS);

  vstate_e          r_state, w_state_next;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_live, r_drain, r_vout_valid, r_frame_done;
  logic [PIX_W-1:0] r_vout;
  logic [PIX_W-1:0] w_la, w_lb, w_la_wdata, w_tap_c;
  logic [SUM_W-1:0] w_sum;
  logic             w_vin_ready, w_accept, w_we, w_out_free, w_load, w_last_out;
  logic             w_col_last, w_row_last;

  assign w_col_last = (r_col == CW'(IM_LEN - 1));
  assign w_row_last = (r_row == RW'(IM_ROWS - 1));
  assign w_out_free = !r_vout_valid || vout_ready;
  assign w_we       = w_accept && !vclrbuffer;
  // Row 0 goes into both buffers so the first output row sees itself as its upper neighbour.
  assign w_la_wdata = (r_state == FILL) ? vin : w_lb;
  assign w_tap_c    = (r_state == FLUSH) ? w_lb : vin;
  assign w_sum      = g121(w_la, w_lb, w_tap_c);

  vlinebuf #(.DEPTH(IM_LEN), .W(PIX_W), .AW(CW)) u_la (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (r_col),
    .i_wdata(w_la_wdata),
    .o_rdata(w_la)
  );

  vlinebuf #(.DEPTH(IM_LEN), .W(PIX_W), .AW(CW)) u_lb (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (r_col),
    .i_wdata(vin),
    .o_rdata(w_lb)
  );

  always_ff @(posedge clk or negedge vres_n) begin
    if (!vres_n) r_state <= FILL;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_vin_ready  = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_last_out   = 1'b0;
    case (r_state)
      FILL: begin
        w_vin_ready = r_live;
        w_accept    = vin_valid && r_live;
        if (w_accept && w_col_last) w_state_next = RUN;
      end
      RUN: begin
        w_vin_ready = r_live && w_out_free;
        w_accept    = vin_valid && w_vin_ready;
        w_load      = w_accept;
        if (w_accept && w_col_last && w_row_last) w_state_next = FLUSH;
      end
      FLUSH: begin
        w_load     = !r_drain && w_out_free;
        w_last_out = r_drain && r_vout_valid && vout_ready;
        if (w_last_out) w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
    if (vclrbuffer) w_state_next = FILL;
  end

  always_ff @(posedge clk or negedge vres_n) begin
    if (!vres_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_live       <= 1'b0;
      r_drain      <= 1'b0;
      r_vout       <= '0;
      r_vout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_frame_done <= 1'b0;
      if (vclrbuffer) begin
        r_col        <= '0;
        r_row        <= '0;
        r_drain      <= 1'b0;
        r_vout_valid <= 1'b0;
      end else begin
        if (w_load) begin
          r_vout       <= w_sum[SUM_W-1:2];
          r_vout_valid <= 1'b1;
        end else if (vout_ready) begin
          r_vout_valid <= 1'b0;
        end
        if (w_accept) begin
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else if (w_load) begin
          // Flush walks the buffered bottom row; r_drain marks the last pixel as loaded.
          r_col <= w_col_last ? '0 : r_col + 1'b1;
          if (w_col_last) r_drain <= 1'b1;
        end
        if (w_last_out) begin
          r_drain      <= 1'b0;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign vin_ready  = w_vin_ready;
  assign vout       = r_vout;
  assign vout_valid = r_vout_valid;
  assign frame_done = r_frame_done;

endmodule
